mux_arbiter: RTL and testbench

//  Round-robin arbiter that shares the 3:1 result mux among three requesters.

---
 rtl/mux_arbiter_pkg.sv | 43 ++++
 rtl/mux_arbiter_pick.sv | 45 ++++
 rtl/mux_arbiter.sv | 132 +++++++++++++
 tb/tb_mux_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux_arbiter_pkg
//   Shared definitions for the round-robin mux arbiter and for any block that
//   decodes its select output.
//   Contents:
//     state_t  - arbiter FSM states (ST_IDLE, ST_GRANT)
//     SEL_*    - mux select encodings (SEL_NONE means no owner, mux out = 0)
//     sel_of   - requester index -> mux select code
//     gnt_of   - requester index -> one-hot grant vector
// ---------------------------------------------------------------------------
package mux_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // The select codes are fixed by the mux wiring, not by requester order,
  // so they are listed explicitly rather than derived from the index.
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_R0   = 2'b10;
  localparam logic [1:0] SEL_R1   = 2'b01;
  localparam logic [1:0] SEL_R2   = 2'b11;

  // Index 3 never occurs; it falls into the default arm so the mapping is
  // total and synthesises without a latch.
  function automatic logic [1:0] sel_of(input logic [1:0] idx);
    case (idx)
      2'd0:    sel_of = SEL_R0;
      2'd1:    sel_of = SEL_R1;
      default: sel_of = SEL_R2;
    endcase
  endfunction

  function automatic logic [2:0] gnt_of(input logic [1:0] idx);
    case (idx)
      2'd0:    gnt_of = 3'b001;
      2'd1:    gnt_of = 3'b010;
      default: gnt_of = 3'b100;
    endcase
  endfunction

endpackage

// File: rtl/mux_arbiter_pick.sv
// ---------------------------------------------------------------------------
// rr_pick3
//   Combinational round-robin pick among three requesters.  The scan starts
//   at the requester just after 'last' (mod 3) and takes the first set bit,
//   so the previous winner always has the lowest priority.
//   Ports:
//     req  in  [2:0]  request vector, bit i = requester i
//     last in  [1:0]  index of the previous winner (0..2)
//     win  out [1:0]  index of the chosen requester (valid when any=1)
//     any  out        at least one request is pending
// ---------------------------------------------------------------------------
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] win,
  output logic       any
);

  // Priority order for each value of last:
  //   last=0 -> 1,2,0   last=1 -> 2,0,1   last=2 -> 0,1,2
  // The third candidate in each order is 'last' itself, reached only when it
  // is the sole requester.
  always_comb begin
    win = 2'd0;
    any = |req;
    case (last)
      2'd0: begin
        if      (req[1]) win = 2'd1;
        else if (req[2]) win = 2'd2;
        else             win = 2'd0;
      end
      2'd1: begin
        if      (req[2]) win = 2'd2;
        else if (req[0]) win = 2'd0;
        else             win = 2'd1;
      end
      default: begin
        if      (req[0]) win = 2'd0;
        else if (req[1]) win = 2'd1;
        else             win = 2'd2;
      end
    endcase
  end

endmodule

// File: rtl/mux_arbiter.sv
// ---------------------------------------------------------------------------
// mux_arbiter
//   Round-robin arbiter sharing a 3:1 result mux among three requesters.
//   Drives the mux select directly.  Every release passes through one
//   no-owner cycle (break-before-make), and a hold limit forces the owner
//   off after MAX_HOLD cycles if someone else is waiting.
//   Parameters:
//     MAX_HOLD  max consecutive grant cycles while another requester waits
//     CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
//   Ports:
//     clk    in        rising-edge clock
//     reset  in        synchronous active-high reset
//     req    in  [2:0] level requests, held high for the whole access
//     sel    out [1:0] registered mux select (10=r0, 01=r1, 11=r2, 00=none)
//     gnt    out [2:0] registered one-hot grant matching sel
//     busy   out       registered, high while a grant is held
// ---------------------------------------------------------------------------
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  output logic [1:0] sel,
  output logic [2:0] gnt,
  output logic       busy
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_n;
  logic [1:0]       owner, owner_n;
  logic [1:0]       last, last_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       sel_n;
  logic [2:0]       gnt_n;
  logic             busy_n;

  logic [1:0]       win;
  logic             any;
  logic             others_waiting;

  rr_pick3 u_pick (
    .req  (req),
    .last (last),
    .win  (win),
    .any  (any)
  );

  // Anyone other than the current owner asking for the mux.  Only meaningful
  // in GRANT, where owner is valid.
  assign others_waiting = |(req & ~gnt_of(owner));

  // Next-state and next-output logic.  Outputs are computed here and then
  // registered, so sel/gnt/busy only ever change on a clock edge.  Every
  // release goes to IDLE with outputs cleared, and IDLE is the only place a
  // new winner is picked, which is what guarantees the one-cycle gap between
  // owners.
  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    cnt_n   = cnt;
    sel_n   = sel;
    gnt_n   = gnt;
    busy_n  = busy;

    case (state)
      ST_IDLE: begin
        sel_n  = SEL_NONE;
        gnt_n  = 3'b000;
        busy_n = 1'b0;
        if (any) begin
          state_n = ST_GRANT;
          owner_n = win;
          last_n  = win;
          cnt_n   = '0;
          sel_n   = sel_of(win);
          gnt_n   = gnt_of(win);
          busy_n  = 1'b1;
        end
      end

      ST_GRANT: begin
        // An owner dropping its request and a timeout on the same edge both
        // lead to the same plain release, so they share one branch.  last
        // keeps the outgoing owner, which puts it at the back of the queue.
        if (!req[owner] || ((cnt == HOLD_LAST) && others_waiting)) begin
          state_n = ST_IDLE;
          sel_n   = SEL_NONE;
          gnt_n   = 3'b000;
          busy_n  = 1'b0;
        end else if (cnt != HOLD_LAST) begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: begin
        state_n = ST_IDLE;
        sel_n   = SEL_NONE;
        gnt_n   = 3'b000;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, pointer, counter and output registers.  Reset starts with last=2
  // so that requester 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      owner <= 2'd0;
      last  <= 2'd2;
      cnt   <= '0;
      sel   <= SEL_NONE;
      gnt   <= 3'b000;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last  <= last_n;
      cnt   <= cnt_n;
      sel   <= sel_n;
      gnt   <= gnt_n;
      busy  <= busy_n;
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_arbiter
//   Self-checking bench for mux_arbiter.  A behavioural model tracks the
//   owner as an integer (-1 = none), the last winner and the number of grant
//   cycles used, and predicts sel/gnt/busy after every edge.  Directed
//   scenarios also carry their own literal expected sequences, and a
//   free-running monitor checks the output invariants on every falling edge.
// ---------------------------------------------------------------------------
module tb_mux_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       reset;
  logic [2:0] req;
  logic [1:0] sel;
  logic [2:0] gnt;
  logic       busy;

  int checks;
  int failures;
  bit inv_en;

  // Behavioural model state
  int m_owner;
  int m_last;
  int m_hold;

  logic [1:0] sel_tab [3] = '{2'b10, 2'b01, 2'b11};

  mux_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .sel   (sel),
    .gnt   (gnt),
    .busy  (busy)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected {sel, gnt, busy} derived from the model's notion of the owner
  function automatic logic [5:0] model_out();
    if (m_owner < 0) return 6'b00_000_0;
    return {sel_tab[m_owner], 3'(1 << m_owner), 1'b1};
  endfunction

  // Advance the model by one edge given the inputs seen at that edge
  task automatic model_edge(input logic [2:0] r, input logic rst);
    if (rst) begin
      m_owner = -1;
      m_last  = 2;
      m_hold  = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= 3; k++) begin
        int i;
        i = (m_last + k) % 3;
        if (r[i] && m_owner < 0) begin
          m_owner = i;
          m_last  = i;
          m_hold  = 1;
        end
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else if (m_hold >= MAX_HOLD && (r & ~(3'(1 << m_owner))) != 3'b000) begin
      m_owner = -1;
    end else begin
      m_hold++;
    end
  endtask

  // Drive one cycle of inputs, take the edge, update the model, then settle
  // to #1 after the edge so outputs can be sampled away from it.
  task automatic applyStimulus(input logic [2:0] r, input logic rst);
    req   = r;
    reset = rst;
    @(posedge clk);
    model_edge(r, rst);
    #1;
  endtask

  // Output invariants, checked every cycle on the falling edge
  always @(negedge clk) begin
    if (inv_en) begin
      logic ok;
      logic [2:0] gsel;
      case (sel)
        2'b10:   gsel = 3'b001;
        2'b01:   gsel = 3'b010;
        2'b11:   gsel = 3'b100;
        default: gsel = 3'b000;
      endcase
      ok = $onehot0(gnt) && (gnt === gsel) &&
           ((sel == 2'b00) == (gnt == 3'b000)) &&
           ((gnt == 3'b000) == (busy == 1'b0));
      checks++;
      if (!ok) begin
        failures++;
        $display("[TB] FAIL invariant @%0t: sel=%b gnt=%b busy=%b, required consistent encoding",
                 $time, sel, gnt, busy);
      end
    end
  end

  // Reset held two cycles with all requests high: outputs stay idle
  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      applyStimulus(3'b111, 1'b1);
      inv_en = 1'b1;
      checks++;
      if ({sel, gnt, busy} !== 6'b00_000_0) begin
        failures++;
        $display("[TB] FAIL reset_cycle%0d: sel=%b gnt=%b busy=%b required 00/000/0",
                 c, sel, gnt, busy);
      end
    end
  endtask

  // Lone requester 1: one-edge latency, release on drop, stays idle
  task automatic test_single();
    logic [5:0] want;
    applyStimulus(3'b010, 1'b0);
    checks++;
    if ({sel, gnt, busy} !== 6'b01_010_1) begin
      failures++;
      $display("[TB] FAIL single_grant: sel=%b gnt=%b busy=%b required 01/010/1", sel, gnt, busy);
    end
    for (int c = 0; c < 4; c++) begin
      applyStimulus(3'b000, 1'b0);
      want = model_out();
      checks++;
      if ({sel, gnt, busy} !== 6'b00_000_0 || want !== 6'b00_000_0) begin
        failures++;
        $display("[TB] FAIL single_idle%0d: sel=%b gnt=%b busy=%b required 00/000/0 (model %b)",
                 c, sel, gnt, busy, want);
      end
    end
  endtask

  // All three requesting; each owner drops for one cycle after two grants
  task automatic test_round_robin();
    logic [2:0] rr_req [10] = '{3'b111, 3'b111, 3'b110, 3'b111, 3'b111,
                                3'b101, 3'b111, 3'b111, 3'b011, 3'b111};
    logic [1:0] rr_sel [10] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01,
                                2'b00, 2'b11, 2'b11, 2'b00, 2'b10};
    logic [5:0] want;
    applyStimulus(3'b000, 1'b1);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(rr_req[c], 1'b0);
      want = model_out();
      checks++;
      if (sel !== rr_sel[c] || {sel, gnt, busy} !== want) begin
        failures++;
        $display("[TB] FAIL rr_step%0d: sel=%b gnt=%b busy=%b required sel=%b (model %b)",
                 c, sel, gnt, busy, rr_sel[c], want);
      end
    end
  endtask

  // r0 holds, r2 joins at grant cycle 3: forced release after 8 cycles
  task automatic test_timeout();
    logic [1:0] exp_sel;
    logic [5:0] want;
    applyStimulus(3'b000, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      applyStimulus((c >= 3) ? 3'b101 : 3'b001, 1'b0);
      exp_sel = (c <= MAX_HOLD) ? 2'b10 : (c == MAX_HOLD + 1) ? 2'b00 : 2'b11;
      want = model_out();
      checks++;
      if (sel !== exp_sel || {sel, gnt, busy} !== want) begin
        failures++;
        $display("[TB] FAIL timeout_cycle%0d: sel=%b gnt=%b busy=%b required sel=%b (model %b)",
                 c, sel, gnt, busy, exp_sel, want);
      end
    end
  endtask

  // r1 alone for 20 cycles: no timeout gap without contention
  task automatic test_no_timeout();
    applyStimulus(3'b000, 1'b1);
    for (int c = 1; c <= 20; c++) begin
      applyStimulus(3'b010, 1'b0);
      checks++;
      if ({sel, gnt, busy} !== 6'b01_010_1) begin
        failures++;
        $display("[TB] FAIL solo_cycle%0d: sel=%b gnt=%b busy=%b required 01/010/1",
                 c, sel, gnt, busy);
      end
    end
  endtask

  // Reset while r2 owns the mux, then r0 wins with everyone requesting
  task automatic test_mid_reset();
    applyStimulus(3'b000, 1'b1);
    applyStimulus(3'b100, 1'b0);
    applyStimulus(3'b100, 1'b0);
    checks++;
    if ({sel, gnt, busy} !== 6'b11_100_1) begin
      failures++;
      $display("[TB] FAIL midrst_owner: sel=%b gnt=%b busy=%b required 11/100/1", sel, gnt, busy);
    end
    applyStimulus(3'b100, 1'b1);
    checks++;
    if ({sel, gnt, busy} !== 6'b00_000_0) begin
      failures++;
      $display("[TB] FAIL midrst_clear: sel=%b gnt=%b busy=%b required 00/000/0", sel, gnt, busy);
    end
    applyStimulus(3'b111, 1'b0);
    checks++;
    if ({sel, gnt, busy} !== 6'b10_001_1) begin
      failures++;
      $display("[TB] FAIL midrst_r0_first: sel=%b gnt=%b busy=%b required 10/001/1", sel, gnt, busy);
    end
  endtask

  // Random request traffic with sticky bits and rare resets against the model
  task automatic test_random();
    logic [2:0] r;
    logic       rst;
    logic [5:0] want;
    r = 3'b000;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(3, 0) == 0) r[b] = ~r[b];
      rst = ($urandom_range(63, 0) == 0);
      applyStimulus(r, rst);
      want = model_out();
      checks++;
      if ({sel, gnt, busy} !== want) begin
        failures++;
        $display("[TB] FAIL random_cycle%0d: req=%b rst=%b sel=%b gnt=%b busy=%b required %b/%b/%b",
                 c, r, rst, sel, gnt, busy, want[5:4], want[3:1], want[0]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    inv_en   = 1'b0;
    m_owner  = -1;
    m_last   = 2;
    m_hold   = 0;
    reset    = 1'b1;
    req      = 3'b000;

    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_no_timeout();
    test_mid_reset();
    test_random();

    @(negedge clk);
    inv_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
